// File: rtl/ft_restore_reader.sv
// ft_restore_reader: replays checkpointed register words and the saved PC from memory.
// Optional feature macro FT_RESTORE_SKIP_X0_EN: skip word 0 (x0), start the restore at index 1.
module ft_restore_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned PC_WORD   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        req_o,
    input  logic        gnt_i,
    output logic [31:0] addr_o,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    input  logic        err_i,
    output logic        we_rf_o,
    output logic [4:0]  addr_rf_o,
    output logic [31:0] data_rf_o,
    output logic        load_pc_o,
    output logic [31:0] pc_o
);

`ifdef FT_RESTORE_SKIP_X0_EN
    localparam logic [5:0] FIRST_IDX = 6'd1;
`else
    localparam logic [5:0] FIRST_IDX = 6'd0;
`endif
    localparam int unsigned LAST_REG = NUM_REGS - 1;
    localparam logic [5:0]  LAST_IDX = LAST_REG[5:0];
    localparam logic [5:0]  PC_IDX   = PC_WORD[5:0];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic        pc_phase_q, pc_phase_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        we_rf_q, we_rf_d;
    logic [4:0]  addr_rf_q, addr_rf_d;
    logic [31:0] data_rf_q, data_rf_d;
    logic        load_pc_q, load_pc_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pc_phase_d = pc_phase_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        we_rf_d    = 1'b0;
        addr_rf_d  = addr_rf_q;
        data_rf_d  = data_rf_q;
        load_pc_d  = 1'b0;
        pc_d       = pc_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = REQ;
                    idx_d      = FIRST_IDX;
                    pc_phase_d = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            REQ: begin
                if (gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rvalid_i) begin
                    if (err_i) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (pc_phase_q) begin
                        load_pc_d = 1'b1;
                        pc_d      = rdata_i;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        we_rf_d   = 1'b1;
                        addr_rf_d = idx_q[4:0];
                        data_rf_d = rdata_i;
                        state_d   = REQ;
                        // The PC word is always fetched after the last register word.
                        if (idx_q == LAST_IDX) begin
                            idx_d      = PC_IDX;
                            pc_phase_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= 6'd0;
            pc_phase_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            we_rf_q    <= 1'b0;
            addr_rf_q  <= 5'd0;
            data_rf_q  <= 32'd0;
            load_pc_q  <= 1'b0;
            pc_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pc_phase_q <= pc_phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            we_rf_q    <= we_rf_d;
            addr_rf_q  <= addr_rf_d;
            data_rf_q  <= data_rf_d;
            load_pc_q  <= load_pc_d;
            pc_q       <= pc_d;
        end
    end

    // Address is only driven while a request is open so it reads 0 in reset/idle.
    assign req_o     = (state_q == REQ);
    assign addr_o    = req_o ? (BASE_ADDR + {24'd0, idx_q, 2'b00}) : 32'd0;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign we_rf_o   = we_rf_q;
    assign addr_rf_o = addr_rf_q;
    assign data_rf_o = data_rf_q;
    assign load_pc_o = load_pc_q;
    assign pc_o      = pc_q;

endmodule
